// File: rtl/switch_port_rx_if.sv
// Port-side byte stream (valid/data/suspend) and packet-FIFO read side of one
// switch input port, bundled so the receiver and its neighbours share one view.
interface switch_port_rx_if;
  logic       valid_ip;
  logic [7:0] data_ip;
  logic       suspend_ip;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_ready;

  modport master (
    output valid_ip, data_ip, out_ready,
    input  suspend_ip, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  valid_ip, data_ip, out_ready,
    output suspend_ip, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/switch_port_rx.sv
// Switch input-port receiver: header check, packet FIFO with commit pointer, drop handling
// and suspend back-pressure. Optional packet counters are built when SWITCH_RX_STATS_EN is defined.
module switch_port_rx #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 16
) (
  input  logic            clk,
  input  logic            reset,
  switch_port_rx_if.slave port,
  output logic [15:0]     pkt_ok_cnt,
  output logic [15:0]     pkt_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT + 1);
  localparam logic [3:0]    SRC_ID  = 4'(4'b0001 << PORT_ID);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_PKT);
  localparam logic [PW-1:0] SUSP_P  = PW'(2 * MAX_PKT);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_PKT);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // Header is rejected on wrong source, null target or target looping back to the source.
  function automatic logic hdr_bad(input logic [7:0] hdr);
    logic [3:0] tgt;
    logic [3:0] src;
    tgt = hdr[7:4];
    src = hdr[3:0];
    hdr_bad = (src != SRC_ID) || (tgt == 4'h0) ||
              ((tgt != 4'hF) && ((tgt & src) != 4'h0));
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_cwr;
  logic [PW-1:0]   r_rd;
  logic [7:0]      r_hold;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   w_len_nxt;
  logic            r_suspend;
  logic [9:0]      r_mem [0:DEPTH-1];

  logic [PW-1:0]   w_occ;
  logic [PW-1:0]   w_free;
  logic            w_hdr_reject;
  logic            w_wr_en;
  logic [9:0]      w_wr_data;
  logic            w_hold_ld;
  logic            w_commit;
  logic            w_rewind;
  logic            w_out_valid;
  logic            w_pop;
  logic [9:0]      w_head;

  // Occupancy includes uncommitted bytes so space reserved by a packet in flight is honoured.
  assign w_occ        = r_wr - r_rd;
  assign w_free       = DEPTH_P - w_occ;
  assign w_hdr_reject = hdr_bad(port.data_ip) || (w_free < MAX_P);

  assign w_out_valid  = (r_rd != r_cwr);
  assign w_pop        = w_out_valid && port.out_ready;
  assign w_head       = r_mem[r_rd[AW-1:0]];

  assign port.out_valid  = w_out_valid;
  assign port.out_data   = w_out_valid ? w_head[7:0] : 8'h00;
  assign port.out_eop    = w_out_valid ? w_head[8]   : 1'b0;
  assign port.out_sop    = w_out_valid ? w_head[9]   : 1'b0;
  assign port.suspend_ip = r_suspend;

  // Next-state and datapath controls of the receive FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wr_en     = 1'b0;
    w_wr_data   = 10'h000;
    w_hold_ld   = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (port.valid_ip) begin
          if (w_hdr_reject) begin
            w_state_nxt = ST_DROP;
          end else begin
            w_hold_ld   = 1'b1;
            w_len_nxt   = ONE_L;
            w_state_nxt = ST_PAYLOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (port.valid_ip) begin
          if (r_len == MAX_L) begin
            // This byte would exceed MAX_PKT: discard everything written so far.
            w_rewind    = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_wr_en     = 1'b1;
            w_wr_data   = {(r_len == ONE_L), 1'b0, r_hold};
            w_hold_ld   = 1'b1;
            w_len_nxt   = r_len + ONE_L;
          end
        end else begin
          if (r_len == ONE_L) begin
            w_rewind    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_wr_en     = 1'b1;
            w_wr_data   = {1'b0, 1'b1, r_hold};
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (port.valid_ip) begin
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, pointers, hold register and suspend flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wr      <= '0;
      r_cwr     <= '0;
      r_rd      <= '0;
      r_hold    <= 8'h00;
      r_len     <= '0;
      r_suspend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      if (w_rewind) begin
        r_wr <= r_cwr;
      end else if (w_wr_en) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_commit) begin
        r_cwr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_hold_ld) begin
        r_hold <= port.data_ip;
      end
      r_suspend <= (w_free < SUSP_P);
    end
  end

  // Packet storage; contents need no reset because visibility is governed by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr[AW-1:0]] <= w_wr_data;
    end
  end

`ifdef SWITCH_RX_STATS_EN
  logic [15:0] r_ok_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_drop_ev;

  assign w_drop_ev = w_rewind || ((r_state == ST_IDLE) && port.valid_ip && w_hdr_reject);

  // Saturating packet counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ok_cnt   <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_commit && (r_ok_cnt != 16'hFFFF)) begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
      if (w_drop_ev && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign pkt_ok_cnt   = r_ok_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
`else
  assign pkt_ok_cnt   = 16'h0000;
  assign pkt_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_switch_port_rx.sv
// Self-checking bench for switch_port_rx: packet table, latency, fill/suspend,
// random traffic and mid-packet reset, with a byte scoreboard on the output side.
module tb_switch_port_rx;

  localparam int DEPTH   = 64;
  localparam int MAX_PKT = 16;

  typedef struct {
    logic [7:0] hdr;
    int         len;
    bit         ok;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] ok_cnt;
  logic [15:0] drop_cnt;

  switch_port_rx_if ifc();

  switch_port_rx #(.PORT_ID(0), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
    .clk          (clk),
    .reset        (reset),
    .port         (ifc),
    .pkt_ok_cnt   (ok_cnt),
    .pkt_drop_cnt (drop_cnt)
  );

  int         n_vec;
  int         n_bad;
  int         n_pop;
  int         exp_ok;
  int         exp_drop;
  logic [9:0] q[$];
  logic [9:0] mon_exp;
  logic [7:0] pkt_buf [0:31];
  bit         rdy_rand;
  logic       rdy_fix;
  vec_t       vecs [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got %0d vectors, expected completion", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int c);
`ifdef SWITCH_RX_STATS_EN
    return (c > 65535) ? 32'd65535 : 32'(c);
`else
    return 32'd0 + 32'(c - c);
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_ok_cnt"}, 32'(ok_cnt), cnt_exp(exp_ok));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), cnt_exp(exp_drop));
  endtask

  // Drives pkt_buf[0..len-1]; returns one cycle after the last byte with valid low.
  task automatic send_buf(input int len, input bit ok);
    for (int i = 0; i < len; i++) begin
      ifc.valid_ip = 1'b1;
      ifc.data_ip  = pkt_buf[i];
      if (ok) q.push_back({(i == 0), (i == len - 1), pkt_buf[i]});
      @(posedge clk);
      #1;
    end
    ifc.valid_ip = 1'b0;
    ifc.data_ip  = 8'h00;
    if (ok) exp_ok++;
    else exp_drop++;
  endtask

  task automatic fill_pkt(input logic [7:0] hdr, input int len);
    pkt_buf[0] = hdr;
    for (int i = 1; i < len; i++) pkt_buf[i] = 8'($urandom);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (((q.size() != 0) || ifc.out_valid) && (w < 4000)) begin
      idle(1);
      w++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(ifc.out_valid), 32'd0);
  endtask

  // Consumer side: apply fixed or random out_ready just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ifc.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Scoreboard: every popped byte must match the next expected byte.
  always @(negedge clk) begin
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      n_pop++;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_byte: got 0x%0h with no packet pending", ifc.out_data);
      end else begin
        mon_exp = q.pop_front();
        chk("stream_byte", {22'd0, ifc.out_sop, ifc.out_eop, ifc.out_data}, {22'd0, mon_exp});
      end
    end
  end

  initial begin
    int p0;
    int w;
    logic [3:0] tgt;
    int len;

    n_vec = 0; n_bad = 0; n_pop = 0; exp_ok = 0; exp_drop = 0;
    rdy_rand = 1'b0; rdy_fix = 1'b0;
    reset = 1'b1;
    ifc.valid_ip = 1'b0; ifc.data_ip = 8'h00; ifc.out_ready = 1'b0;

    vecs[0]  = '{8'hF1, 4,  1'b1};
    vecs[1]  = '{8'h31, 3,  1'b0};
    vecs[2]  = '{8'h02, 3,  1'b0};
    vecs[3]  = '{8'h01, 3,  1'b0};
    vecs[4]  = '{8'h21, 1,  1'b0};
    vecs[5]  = '{8'h21, 17, 1'b0};
    vecs[6]  = '{8'h21, 4,  1'b1};
    vecs[7]  = '{8'h11, 2,  1'b0};
    vecs[8]  = '{8'hF2, 3,  1'b0};
    vecs[9]  = '{8'h41, 2,  1'b1};
    vecs[10] = '{8'h81, 16, 1'b1};
    vecs[11] = '{8'hE1, 5,  1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_data", 32'(ifc.out_data), 32'd0);
    chk("rst_out_sop", 32'(ifc.out_sop), 32'd0);
    chk("rst_out_eop", 32'(ifc.out_eop), 32'd0);
    chk("rst_suspend", 32'(ifc.suspend_ip), 32'd0);
    check_counts("rst");
    reset = 1'b0;
    idle(2);

    // Basic packet and output latency
    rdy_fix = 1'b1;
    idle(2);
    pkt_buf[0] = 8'h21; pkt_buf[1] = 8'hAA; pkt_buf[2] = 8'hBB;
    send_buf(3, 1'b1);
    chk("lat_t1_valid", 32'(ifc.out_valid), 32'd0);
    idle(1);
    chk("lat_t2_valid", 32'(ifc.out_valid), 32'd1);
    chk("lat_t2_sop", 32'(ifc.out_sop), 32'd1);
    chk("lat_t2_data", 32'(ifc.out_data), 32'h21);
    wait_drain();
    check_counts("basic");

    // Header / length table
    for (int i = 0; i < 12; i++) begin
      fill_pkt(vecs[i].hdr, vecs[i].len);
      send_buf(vecs[i].len, vecs[i].ok);
      idle(2);
      check_counts("table");
    end
    wait_drain();

    // Fill with out_ready low, suspend threshold, forced packet without space
    rdy_fix = 1'b0;
    idle(3);
    p0 = n_pop;
    for (int k = 0; k < 3; k++) begin
      fill_pkt(8'h21, 16);
      send_buf(16, 1'b1);
      idle(2);
      chk("fill_suspend", 32'(ifc.suspend_ip), (k == 2) ? 32'd1 : 32'd0);
    end
    fill_pkt(8'h41, 2);
    send_buf(2, 1'b1);
    idle(2);
    fill_pkt(8'h81, 16);
    send_buf(16, 1'b0);
    idle(2);
    check_counts("fill");
    chk("fill_held_valid", 32'(ifc.out_valid), 32'd1);
    rdy_fix = 1'b1;
    wait_drain();
    chk("fill_pop_count", 32'(n_pop - p0), 32'd50);
    idle(2);
    chk("fill_suspend_release", 32'(ifc.suspend_ip), 32'd0);

    // Random legal traffic with random out_ready, sender honouring suspend
    rdy_rand = 1'b1;
    for (int k = 0; k < 100; k++) begin
      w = 0;
      while (ifc.suspend_ip && (w < 2000)) begin
        idle(1);
        w++;
      end
      if (w >= 2000) chk("rand_suspend_release", 32'(ifc.suspend_ip), 32'd0);
      tgt = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(1, 7) * 2);
      len = $urandom_range(2, MAX_PKT);
      fill_pkt({tgt, 4'h1}, len);
      send_buf(len, 1'b1);
      idle(2);
    end
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    idle(2);
    wait_drain();
    check_counts("random");

    // Reset in the middle of a payload
    rdy_fix = 1'b0;
    idle(3);
    pkt_buf[0] = 8'h21; pkt_buf[1] = 8'h11; pkt_buf[2] = 8'h22; pkt_buf[3] = 8'h33;
    send_buf(4, 1'b1);
    idle(2);
    chk("mid_pre_valid", 32'(ifc.out_valid), 32'd1);
    ifc.valid_ip = 1'b1; ifc.data_ip = 8'h21; idle(1);
    ifc.data_ip = 8'h44; idle(1);
    ifc.data_ip = 8'h55; idle(1);
    reset = 1'b1;
    q.delete();
    exp_ok = 0;
    exp_drop = 0;
    #1;
    chk("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("mid_rst_data", 32'(ifc.out_data), 32'd0);
    chk("mid_rst_sop", 32'(ifc.out_sop), 32'd0);
    chk("mid_rst_suspend", 32'(ifc.suspend_ip), 32'd0);
    check_counts("mid_rst");
    ifc.valid_ip = 1'b0; ifc.data_ip = 8'h00;
    idle(1);
    reset = 1'b0;
    rdy_fix = 1'b1;
    idle(3);
    chk("post_rst_empty", 32'(ifc.out_valid), 32'd0);
    pkt_buf[0] = 8'h81; pkt_buf[1] = 8'h5A; pkt_buf[2] = 8'hC3;
    send_buf(3, 1'b1);
    idle(2);
    wait_drain();
    check_counts("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
